// File: rtl/axis_decim_sum_if.sv
// Valid/ready stream bundle for axis_decim_sum: one payload word with its handshake.
// The master drives tdata/tvalid and the slave drives tready.
interface axis_decim_sum_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_decim_sum.sv
// Decimating boxcar accumulator: sums each group of decim+1 signed samples into one output.
// Define AXIS_DECIM_SUM_SAT_EN to saturate every addition instead of wrapping.
module axis_decim_sum #(
  parameter int DATA_WIDTH  = 8,
  parameter int SUM_WIDTH   = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [DECIM_WIDTH-1:0] decim,
  axis_decim_sum_if.slave        s,
  axis_decim_sum_if.master       m
);

  logic signed [SUM_WIDTH-1:0] acc_reg;
  logic        [DECIM_WIDTH-1:0] cnt_reg;
  logic        [DECIM_WIDTH-1:0] len_reg;
  logic        [SUM_WIDTH-1:0] data_reg;
  logic                        valid_reg;

  logic signed [SUM_WIDTH-1:0] sample_ext;
  logic signed [SUM_WIDTH-1:0] raw_sum;
  logic signed [SUM_WIDTH-1:0] sum_next;
  logic                        accept;
  logic                        last;

  assign sample_ext = SUM_WIDTH'(signed'(s.tdata));
  assign raw_sum    = acc_reg + sample_ext;

`ifdef AXIS_DECIM_SUM_SAT_EN
  // Overflow only when both operands share a sign and the result's sign differs.
  always_comb begin
    sum_next = raw_sum;
    if ((acc_reg[SUM_WIDTH-1] == sample_ext[SUM_WIDTH-1]) &&
        (raw_sum[SUM_WIDTH-1] != acc_reg[SUM_WIDTH-1])) begin
      sum_next = acc_reg[SUM_WIDTH-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                      : {1'b0, {(SUM_WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_next = raw_sum;
`endif

  // Single output register: stall all input while a sum is waiting.
  assign s.tready = !valid_reg || m.tready;
  assign accept   = s.tvalid && s.tready;
  assign last     = (cnt_reg == len_reg);

  assign m.tdata  = data_reg;
  assign m.tvalid = valid_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      len_reg   <= decim;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (valid_reg && m.tready) begin
        valid_reg <= 1'b0;
      end
      if (accept) begin
        if (last) begin
          data_reg  <= sum_next;
          valid_reg <= 1'b1;
          acc_reg   <= '0;
          cnt_reg   <= '0;
          len_reg   <= decim;
        end else begin
          acc_reg <= sum_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_decim_sum.sv
// Randomized and directed self-checking bench for axis_decim_sum against a group-sum model.
module tb_axis_decim_sum;
  localparam int DW = 8;
  localparam int SW = 10;
  localparam int CW = 8;
  localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (SW - 1));

  logic          clock = 1'b0;
  logic          resetn;
  logic [CW-1:0] decim;

  axis_decim_sum_if #(.WIDTH(DW)) s_bus ();
  axis_decim_sum_if #(.WIDTH(SW)) m_bus ();

  axis_decim_sum #(.DATA_WIDTH(DW), .SUM_WIDTH(SW), .DECIM_WIDTH(CW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .decim  (decim),
    .s      (s_bus),
    .m      (m_bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: samples of the open group, its length, and sums not yet taken downstream.
  int          grp[$];
  int          glen;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Sum with each addition wrapped or clamped to SW bits.
  function automatic logic [SW-1:0] ref_sum(input int g[$]);
    longint acc = 0;
    foreach (g[i]) begin
      acc = acc + g[i];
`ifdef AXIS_DECIM_SUM_SAT_EN
      if (acc > SMAX) acc = SMAX;
      if (acc < SMIN) acc = SMIN;
`else
      acc = longint'($signed(SW'(acc)));
`endif
    end
    return SW'(acc);
  endfunction

  // One cycle, entered just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic [CW-1:0] dc);
    logic s_acc, m_acc;
    check("m_tvalid", m_bus.tvalid, exp_q.size() != 0);
    if (m_bus.tvalid && exp_q.size() != 0) check("m_tdata", m_bus.tdata, exp_q[0]);
    s_bus.tvalid = sv;
    s_bus.tdata  = sd;
    m_bus.tready = mr;
    decim        = dc;
    #1;
    check("s_tready", s_bus.tready, !(exp_q.size() != 0 && !mr));
    s_acc = s_bus.tvalid && s_bus.tready;
    m_acc = m_bus.tvalid && m_bus.tready;
    if (m_acc) begin
      obs_q.push_back(m_bus.tdata);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (s_acc) begin
      grp.push_back(int'($signed(sd)));
      if (grp.size() == glen + 1) begin
        exp_q.push_back(ref_sum(grp));
        grp.delete();
        glen = int'(dc);
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [CW-1:0] dc);
    resetn       = 1'b0;
    s_bus.tvalid = 1'b0;
    s_bus.tdata  = '0;
    m_bus.tready = 1'b1;
    decim        = dc;
    @(negedge clock);
    @(negedge clock);
    check("rst_tvalid", m_bus.tvalid, 1'b0);
    check("rst_tdata", m_bus.tdata, '0);
    check("rst_tready", s_bus.tready, 1'b1);
    grp.delete();
    exp_q.delete();
    obs_q.delete();
    glen   = int'(dc);
    resetn = 1'b1;
  endtask

  task automatic idle(input int n, input logic [CW-1:0] dc);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, dc);
  endtask

  initial begin
    logic [SW-1:0] exp_val;
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    resetn = 1'b0;
    decim  = '0;
    s_bus.tvalid = 1'b0;
    s_bus.tdata  = '0;
    m_bus.tready = 1'b1;
    @(negedge clock);

    // decim=3, samples 1..8 -> 10, 26
    do_reset(8'd3);
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 8'd3);
    idle(2, 8'd3);
    check("d3_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("d3_sum0", obs_q[0], 10);
      check("d3_sum1", obs_q[1], 26);
    end

    // decim=0 pass-through, back to back
    do_reset(8'd0);
    step(1'b1, DW'(-3), 1'b1, 8'd0);
    step(1'b1, DW'(5), 1'b1, 8'd0);
    step(1'b1, DW'(-128), 1'b1, 8'd0);
    idle(2, 8'd0);
    check("pass_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      exp_val = SW'(-3);   check("pass0", obs_q[0], exp_val);
      exp_val = SW'(5);    check("pass1", obs_q[1], exp_val);
      exp_val = SW'(-128); check("pass2", obs_q[2], exp_val);
    end

    // decim=1 with back-pressure
    do_reset(8'd1);
    step(1'b1, 8'd1, 1'b1, 8'd1);
    step(1'b1, 8'd2, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd3, 1'b0, 8'd1);
      check("stall_tready", s_bus.tready, 1'b0);
      check("stall_tdata", m_bus.tdata, 3);
    end
    step(1'b1, 8'd3, 1'b1, 8'd1);
    step(1'b1, 8'd4, 1'b1, 8'd1);
    idle(2, 8'd1);
    check("bp_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("bp_sum0", obs_q[0], 3);
      check("bp_sum1", obs_q[1], 7);
    end

    // decim change mid-group
    do_reset(8'd3);
    step(1'b1, 8'd10, 1'b1, 8'd3);
    step(1'b1, 8'd20, 1'b1, 8'd3);
    step(1'b1, 8'd30, 1'b1, 8'd1);
    step(1'b1, 8'd40, 1'b1, 8'd1);
    step(1'b1, 8'd5, 1'b1, 8'd1);
    step(1'b1, 8'd6, 1'b1, 8'd1);
    idle(2, 8'd1);
    check("chg_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("chg_sum0", obs_q[0], 100);
      check("chg_sum1", obs_q[1], 11);
    end

    // overflow: 8 x 127 = 1016 exceeds the SW-bit range
    do_reset(8'd7);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd127, 1'b1, 8'd7);
    idle(2, 8'd7);
`ifdef AXIS_DECIM_SUM_SAT_EN
    exp_val = SW'(SMAX);
`else
    exp_val = SW'(1016);
`endif
    check("ovf_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("ovf_sum", obs_q[0], exp_val);

    // reset mid-group
    do_reset(8'd3);
    step(1'b1, 8'd9, 1'b1, 8'd3);
    step(1'b1, 8'd9, 1'b1, 8'd3);
    do_reset(8'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b1, 8'd3);
    idle(2, 8'd3);
    check("rstmid_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("rstmid_sum", obs_q[0], 4);

    // randomized traffic
    rc = 8'd2;
    do_reset(rc);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        rc = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 4));
      rd = DW'($urandom);
      if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
      if ($urandom_range(0, 999) == 0) do_reset(rc);
      step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 9) < 7, rc);
    end
    idle(3, rc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
